rvc_instr_packer: RTL

- Streaming RV32C compressor and packer. It is the encode-side counterpart of the fetch-stage compressed decoder.
- It accepts uncompressed 32-bit instructions, substitutes the canonical 16-bit RVC encoding wherever one exists, and packs the result into little-endian 32-bit words.
- Consumers: the boot-image/trace path and the self-checking fetch bench. Packed words are replayed into fetch and decoded back.

---
 rtl/rvc_instr_packer_pkg.sv | 43 ++++
 rtl/rvc_instr_packer_compress.sv | 141 ++++++++++++++
 rtl/rvc_instr_packer.sv | 110 +++++++++++
 3 files changed

// File: rtl/rvc_instr_packer_pkg.sv
// Shared RV32 opcode and RVC quadrant constants for the compressor and packer.
// Also holds the {can_c, c16} result type and a compressed-register helper.
// No ports; imported by rvc_compress and rvc_instr_packer.
package rvc_instr_packer_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [1:0] RVC_Q0   = 2'b00;
    localparam logic [1:0] RVC_Q1   = 2'b01;
    localparam logic [1:0] RVC_Q2   = 2'b10;
    localparam logic [1:0] RVC_FULL = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_SP   = 5'd2;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [15:0] C_EBREAK     = 16'h9002;
    localparam logic [15:0] C_NOP        = 16'h0001;

    typedef struct packed {
        logic        can_c;
        logic [15:0] c16;
    } rvc_res_t;

    // x8..x15 are the only registers reachable through the 3-bit rd'/rs1'/rs2' fields.
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

    function automatic rvc_res_t emit(input logic [15:0] c);
        return {1'b1, c};
    endfunction

endpackage

// File: rtl/rvc_instr_packer_compress.sv
// Combinational RV32 -> RVC compressor: can_c_o=1 only when c16_o decodes back bit-exactly.
// Ports: instr_i (32-bit uncompressed), can_c_o, c16_o (valid only with can_c_o).
// Reserved encodings and HINTs are never produced; such inputs stay 32-bit.
module rvc_compress
    import rvc_instr_packer_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        can_c_o,
    output logic [15:0] c16_o
);

    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [12:0] imm_b;
    logic [20:0] imm_j;
    logic        fit6_i;
    rvc_res_t    res;

    assign opc    = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign f3     = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign f7     = instr_i[31:25];
    assign imm_i  = instr_i[31:20];
    assign imm_s  = {instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign fit6_i = imm_i[11:5] == {7{imm_i[5]}};

    always_comb begin
        res = '0;
        case (opc)
            OPCODE_OP_IMM: begin
                if (f3 == 3'b000) begin
                    // addi16sp is checked before c.addi so sp adjustments take the canonical form.
                    if (rd == REG_SP && rs1 == REG_SP && imm_i[3:0] == 4'd0 &&
                        imm_i != 12'd0 && imm_i[11:9] == {3{imm_i[9]}})
                        res = emit({3'b011, imm_i[9], REG_SP, imm_i[4], imm_i[6],
                                    imm_i[8:7], imm_i[5], RVC_Q1});
                    else if (rs1 == REG_SP && is_creg(rd) && imm_i[11:10] == 2'd0 &&
                             imm_i[1:0] == 2'd0 && imm_i != 12'd0)
                        res = emit({3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3],
                                    rd[2:0], RVC_Q0});
                    else if (rs1 == REG_ZERO && rd != REG_ZERO && fit6_i)
                        res = emit({3'b010, imm_i[5], rd, imm_i[4:0], RVC_Q1});
                    else if (rd == REG_ZERO && rs1 == REG_ZERO && imm_i == 12'd0)
                        res = emit(C_NOP);
                    else if (rd == rs1 && rd != REG_ZERO && imm_i != 12'd0 && fit6_i)
                        res = emit({3'b000, imm_i[5], rd, imm_i[4:0], RVC_Q1});
                end else if (f3 == 3'b001) begin
                    if (f7 == 7'd0 && rd == rs1 && rd != REG_ZERO && rs2 != 5'd0)
                        res = emit({3'b000, 1'b0, rd, rs2, RVC_Q2});
                end else if (f3 == 3'b101) begin
                    if (rd == rs1 && is_creg(rd) && rs2 != 5'd0) begin
                        if (f7 == 7'b0000000)
                            res = emit({3'b100, 1'b0, 2'b00, rd[2:0], rs2, RVC_Q1});
                        else if (f7 == 7'b0100000)
                            res = emit({3'b100, 1'b0, 2'b01, rd[2:0], rs2, RVC_Q1});
                    end
                end else if (f3 == 3'b111) begin
                    if (rd == rs1 && is_creg(rd) && fit6_i)
                        res = emit({3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], RVC_Q1});
                end
            end
            OPCODE_LUI: begin
                if (rd != REG_ZERO && rd != REG_SP && instr_i[31:12] != 20'd0 &&
                    instr_i[31:17] == {15{instr_i[17]}})
                    res = emit({3'b011, instr_i[17], rd, instr_i[16:12], RVC_Q1});
            end
            OPCODE_OP: begin
                if (f7 == 7'd0 && f3 == 3'b000) begin
                    // rs1=x0 goes to c.mv; c.add never carries rs1=x0, so no HINT leaks out.
                    if (rs1 == REG_ZERO && rd != REG_ZERO && rs2 != REG_ZERO)
                        res = emit({3'b100, 1'b0, rd, rs2, RVC_Q2});
                    else if (rd == rs1 && rd != REG_ZERO && rs2 != REG_ZERO)
                        res = emit({3'b100, 1'b1, rd, rs2, RVC_Q2});
                end else if (rd == rs1 && is_creg(rd) && is_creg(rs2)) begin
                    if (f7 == 7'b0100000 && f3 == 3'b000)
                        res = emit({3'b100, 1'b0, 2'b11, rd[2:0], 2'b00, rs2[2:0], RVC_Q1});
                    else if (f7 == 7'd0 && f3 == 3'b100)
                        res = emit({3'b100, 1'b0, 2'b11, rd[2:0], 2'b01, rs2[2:0], RVC_Q1});
                    else if (f7 == 7'd0 && f3 == 3'b110)
                        res = emit({3'b100, 1'b0, 2'b11, rd[2:0], 2'b10, rs2[2:0], RVC_Q1});
                    else if (f7 == 7'd0 && f3 == 3'b111)
                        res = emit({3'b100, 1'b0, 2'b11, rd[2:0], 2'b11, rs2[2:0], RVC_Q1});
                end
            end
            OPCODE_LOAD: begin
                if (f3 == 3'b010 && imm_i[1:0] == 2'd0) begin
                    if (rs1 == REG_SP && rd != REG_ZERO && imm_i[11:8] == 4'd0)
                        res = emit({3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], RVC_Q2});
                    else if (is_creg(rs1) && is_creg(rd) && imm_i[11:7] == 5'd0)
                        res = emit({3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6],
                                    rd[2:0], RVC_Q0});
                end
            end
            OPCODE_STORE: begin
                if (f3 == 3'b010 && imm_s[1:0] == 2'd0) begin
                    if (rs1 == REG_SP && imm_s[11:8] == 4'd0)
                        res = emit({3'b110, imm_s[5:2], imm_s[7:6], rs2, RVC_Q2});
                    else if (is_creg(rs1) && is_creg(rs2) && imm_s[11:7] == 5'd0)
                        res = emit({3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6],
                                    rs2[2:0], RVC_Q0});
                end
            end
            OPCODE_BRANCH: begin
                if ((f3 == 3'b000 || f3 == 3'b001) && rs2 == REG_ZERO && is_creg(rs1) &&
                    imm_b[12:8] == {5{imm_b[8]}})
                    res = emit({2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6],
                                imm_b[2:1], imm_b[5], RVC_Q1});
            end
            OPCODE_JAL: begin
                // rd=x0 -> c.j (funct3 101), rd=x1 -> c.jal (funct3 001).
                if ((rd == REG_ZERO || rd == REG_RA) && imm_j[20:11] == {10{imm_j[11]}})
                    res = emit({~rd[0], 2'b01, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10],
                                imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], RVC_Q1});
            end
            OPCODE_JALR: begin
                if (f3 == 3'b000 && imm_i == 12'd0 && rs1 != REG_ZERO &&
                    (rd == REG_ZERO || rd == REG_RA))
                    res = emit({3'b100, rd[0], rs1, 5'd0, RVC_Q2});
            end
            OPCODE_SYSTEM: begin
                if (instr_i == INSTR_EBREAK)
                    res = emit(C_EBREAK);
            end
            default: res = '0;
        endcase
    end

    assign can_c_o = res.can_c;
    assign c16_o   = res.c16;

endmodule

// File: rtl/rvc_instr_packer.sv
// Streaming packer: compresses RV32 instructions where possible, packs halfwords LE into 32-bit words.
// Ports: in_* (valid/ready, 32-bit instr), flush_i, out_* (valid/ready, 32-bit word), err_o, idle_o, n_comp_o.
// One registered output slot; in_ready_o = slot empty or draining, no in_valid->out_valid path.
module rvc_instr_packer
    import rvc_instr_packer_pkg::*;
#(
    parameter bit          EN_RVC   = 1'b1,
    parameter logic [15:0] PAD_HALF = 16'h0001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        err_o,
    output logic        idle_o,
    output logic [15:0] n_comp_o
);

    logic [15:0] hold_q, hold_d;
    logic        hold_v_q, hold_v_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        err_q, err_d;
    logic [15:0] n_comp_q, n_comp_d;

    logic        can_c;
    logic [15:0] c16;
    logic        slot_free;
    logic        in_acc;
    logic        use_c;

    rvc_compress u_compress (
        .instr_i (in_instr_i),
        .can_c_o (can_c),
        .c16_o   (c16)
    );

    assign slot_free = !out_valid_q || out_ready_i;
    assign in_acc    = in_valid_i && slot_free;
    assign use_c     = EN_RVC && can_c;

    always_comb begin
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        out_valid_d = out_valid_q && !out_ready_i;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        n_comp_d    = n_comp_q;
        if (in_acc) begin
            if (in_instr_i[1:0] != RVC_FULL) begin
                // Malformed input is swallowed; pending halfword is kept as-is.
                err_d = 1'b1;
            end else if (use_c) begin
                if (n_comp_q != 16'hFFFF)
                    n_comp_d = n_comp_q + 16'd1;
                if (hold_v_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {c16, hold_q};
                    hold_v_d    = 1'b0;
                end else begin
                    hold_d   = c16;
                    hold_v_d = 1'b1;
                end
            end else if (hold_v_q) begin
                // Full instruction straddles the word boundary; its upper half stays pending.
                out_valid_d = 1'b1;
                out_data_d  = {in_instr_i[15:0], hold_q};
                hold_d      = in_instr_i[31:16];
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = in_instr_i;
            end
        end else if (flush_i && hold_v_q && slot_free) begin
            out_valid_d = 1'b1;
            out_data_d  = {PAD_HALF, hold_q};
            hold_v_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q      <= 16'd0;
            hold_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            err_q       <= 1'b0;
            n_comp_q    <= 16'd0;
        end else begin
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            n_comp_q    <= n_comp_d;
        end
    end

    assign in_ready_o  = slot_free;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_o       = err_q;
    assign idle_o      = !hold_v_q && !out_valid_q;
    assign n_comp_o    = n_comp_q;

endmodule
